// File: rtl/branch_trap_resolver.sv
// branch_trap_resolver: ID-stage consumer of the branch comparator results.
// Issues registered PC redirects for taken branches, sequences precise teq
// traps (flush, EPC/cause capture, vector, wait for eret) and stalls ID
// while branch operands are still being forwarded.
// Optional statistics counters are enabled by defining BRANCH_TRAP_STATS_EN.
module branch_trap_resolver #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
  parameter logic [4:0]  CAUSE_TEQ  = 5'd13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_is_branch_op,
  input  logic        id_is_teq_op,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_branch_target,
  input  logic        is_branch,
  input  logic        is_teq,
  input  logic        operand_ready,
  input  logic        ex_stall,
  input  logic        eret_valid,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_if,
  output logic        flush_id,
  output logic        stall_id,
  output logic [31:0] epc,
  output logic [4:0]  cause,
  output logic        trap_active,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_taken,
  output logic [31:0] stat_traps
);

  // S_WAIT_OPND_H is the operand wait taken from inside the handler, so the
  // handler context (trap_active) survives a stalled branch.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_OPND,
    S_TRAP_FLUSH,
    S_TRAP_VECTOR,
    S_IN_HANDLER,
    S_WAIT_OPND_H
  } state_t;

  state_t      state_q, state_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        flush_if_q, flush_if_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  cause_q, cause_d;
  logic        resolve;
  logic        in_handler;

`ifdef BRANCH_TRAP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_taken_q, stat_taken_d;
  logic [31:0] stat_traps_q, stat_traps_d;
`endif

  // Next-state, registered pulse and capture logic
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_if_d       = 1'b0;
    epc_d            = epc_q;
    cause_d          = cause_q;
    resolve          = 1'b0;
    in_handler       = (state_q == S_IN_HANDLER) || (state_q == S_WAIT_OPND_H);
`ifdef BRANCH_TRAP_STATS_EN
    stat_branches_d  = stat_branches_q;
    stat_taken_d     = stat_taken_q;
    stat_traps_d     = stat_traps_q;
`endif
    if (!ex_stall) begin
      case (state_q)
        S_IDLE, S_IN_HANDLER: begin
          if (state_q == S_IN_HANDLER && eret_valid) begin
            state_d          = S_IDLE;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = epc_q + 32'd4;
            flush_if_d       = 1'b1;
          end else if (id_valid && (id_is_branch_op || id_is_teq_op)) begin
            if (operand_ready) resolve = 1'b1;
            else state_d = (state_q == S_IDLE) ? S_WAIT_OPND : S_WAIT_OPND_H;
          end
        end
        S_WAIT_OPND, S_WAIT_OPND_H: begin
          if (operand_ready) begin
            state_d = (state_q == S_WAIT_OPND) ? S_IDLE : S_IN_HANDLER;
            resolve = id_valid && (id_is_branch_op || id_is_teq_op);
          end
        end
        S_TRAP_FLUSH: begin
          state_d          = S_TRAP_VECTOR;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = EXC_VECTOR;
        end
        S_TRAP_VECTOR: state_d = S_IN_HANDLER;
        default:       state_d = S_IDLE;
      endcase

      if (resolve) begin
        if (id_is_teq_op && is_teq && !in_handler) begin
          state_d = S_TRAP_FLUSH;
          epc_d   = id_pc;
          cause_d = CAUSE_TEQ;
`ifdef BRANCH_TRAP_STATS_EN
          stat_traps_d = stat_traps_q + 32'd1;
`endif
        end else if (id_is_branch_op) begin
`ifdef BRANCH_TRAP_STATS_EN
          stat_branches_d = stat_branches_q + 32'd1;
`endif
          if (is_branch) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = id_branch_target;
            flush_if_d       = 1'b1;
`ifdef BRANCH_TRAP_STATS_EN
            stat_taken_d = stat_taken_q + 32'd1;
`endif
          end
        end
      end
    end
  end

  // State and registered output flops with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_if_q       <= 1'b0;
      epc_q            <= '0;
      cause_q          <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_if_q       <= flush_if_d;
      epc_q            <= epc_d;
      cause_q          <= cause_d;
    end
  end

`ifdef BRANCH_TRAP_STATS_EN
  // Statistics counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
      stat_traps_q    <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_taken_q    <= stat_taken_d;
      stat_traps_q    <= stat_traps_d;
    end
  end
  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;
  assign stat_traps    = stat_traps_q;
`else
  assign stat_branches = '0;
  assign stat_taken    = '0;
  assign stat_traps    = '0;
`endif

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_if       = flush_if_q | (state_q == S_TRAP_FLUSH);
  assign flush_id       = (state_q == S_TRAP_FLUSH);
  assign stall_id       = (state_q == S_WAIT_OPND) || (state_q == S_WAIT_OPND_H);
  assign epc            = epc_q;
  assign cause          = cause_q;
  assign trap_active    = in_handler;

endmodule

// File: tb/tb_branch_trap_resolver.sv
// Testbench for branch_trap_resolver: directed scenarios plus randomized
// traffic, all checked every cycle against a behavioural reference model.
module tb_branch_trap_resolver;

  localparam logic [31:0] EXC = 32'h0000_0004;
  localparam logic [4:0]  CTQ = 5'd13;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_is_branch_op, id_is_teq_op;
  logic [31:0] id_pc, id_branch_target;
  logic        is_branch, is_teq, operand_ready, ex_stall, eret_valid;
  logic        redirect_valid, flush_if, flush_id, stall_id, trap_active;
  logic [31:0] redirect_pc, epc, stat_branches, stat_taken, stat_traps;
  logic [4:0]  cause;

  int checks = 0;
  int failures = 0;

  // Reference model: trap progress as a countdown, handler/wait as flags
  bit          m_wait, m_handler, m_rv, m_fif;
  int          m_cd;
  logic [31:0] m_rpc, m_epc, m_br, m_tk, m_tr;
  logic [4:0]  m_cause;

  branch_trap_resolver #(.EXC_VECTOR(EXC), .CAUSE_TEQ(CTQ)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch_op(id_is_branch_op),
    .id_is_teq_op(id_is_teq_op), .id_pc(id_pc), .id_branch_target(id_branch_target),
    .is_branch(is_branch), .is_teq(is_teq), .operand_ready(operand_ready),
    .ex_stall(ex_stall), .eret_valid(eret_valid), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_if(flush_if), .flush_id(flush_id),
    .stall_id(stall_id), .epc(epc), .cause(cause), .trap_active(trap_active),
    .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_traps(stat_traps)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; id_valid = 1'b0; id_is_branch_op = 1'b0; id_is_teq_op = 1'b0;
    id_pc = '0; id_branch_target = '0; is_branch = 1'b0; is_teq = 1'b0;
    operand_ready = 1'b1; ex_stall = 1'b0; eret_valid = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    bit nrv, nfif, res;
    nrv = 0; nfif = 0; res = 0;
    if (rst) begin
      m_wait = 0; m_handler = 0; m_cd = 0; m_rpc = '0; m_epc = '0; m_cause = '0;
      m_br = '0; m_tk = '0; m_tr = '0;
    end else if (!ex_stall) begin
      if (m_cd == 2) begin
        m_cd = 1; nrv = 1; m_rpc = EXC;
      end else if (m_cd == 1) begin
        m_cd = 0; m_handler = 1;
      end else if (m_wait) begin
        if (operand_ready) begin
          m_wait = 0;
          res = id_valid && (id_is_branch_op || id_is_teq_op);
        end
      end else if (m_handler && eret_valid) begin
        m_handler = 0; nrv = 1; m_rpc = m_epc + 32'd4; nfif = 1;
      end else if (id_valid && (id_is_branch_op || id_is_teq_op)) begin
        if (operand_ready) res = 1;
        else m_wait = 1;
      end
      if (res) begin
        if (id_is_teq_op && is_teq && !m_handler) begin
          m_cd = 2; m_epc = id_pc; m_cause = CTQ; m_tr = m_tr + 1;
        end else if (id_is_branch_op) begin
          m_br = m_br + 1;
          if (is_branch) begin
            m_tk = m_tk + 1; nrv = 1; m_rpc = id_branch_target; nfif = 1;
          end
        end
      end
    end
    m_rv = nrv; m_fif = nfif;
  endtask

  task automatic check_model();
    check_eq("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
    check_eq("redirect_pc", redirect_pc, m_rpc);
    check_eq("flush_if", {31'd0, flush_if}, {31'd0, m_fif || (m_cd == 2)});
    check_eq("flush_id", {31'd0, flush_id}, {31'd0, m_cd == 2});
    check_eq("stall_id", {31'd0, stall_id}, {31'd0, m_wait});
    check_eq("trap_active", {31'd0, trap_active}, {31'd0, m_handler});
    check_eq("epc", epc, m_epc);
    check_eq("cause", {27'd0, cause}, {27'd0, m_cause});
`ifdef BRANCH_TRAP_STATS_EN
    check_eq("stat_branches", stat_branches, m_br);
    check_eq("stat_taken", stat_taken, m_tk);
    check_eq("stat_traps", stat_traps, m_tr);
`else
    check_eq("stat_branches", stat_branches, 32'd0);
    check_eq("stat_taken", stat_taken, 32'd0);
    check_eq("stat_traps", stat_traps, 32'd0);
`endif
  endtask

  // One cycle: model follows the posedge, outputs checked at the next negedge
  task automatic tick();
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive_branch(input logic [31:0] pc, input logic [31:0] tgt,
                              input logic taken, input logic rdy);
    idle_inputs();
    id_valid = 1'b1; id_is_branch_op = 1'b1; id_pc = pc; id_branch_target = tgt;
    is_branch = taken; operand_ready = rdy;
  endtask

  task automatic drive_teq(input logic [31:0] pc);
    idle_inputs();
    id_valid = 1'b1; id_is_teq_op = 1'b1; id_pc = pc; is_teq = 1'b1;
  endtask

  initial begin
    int op;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    tick(); tick();
    check_eq("reset_rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("reset_pc", redirect_pc, 32'd0);

    // Taken beq
    drive_branch(32'h100, 32'h200, 1'b1, 1'b1); tick();
    check_eq("beq_rv", {31'd0, redirect_valid}, 32'd1);
    check_eq("beq_pc", redirect_pc, 32'h200);
    check_eq("beq_fif", {31'd0, flush_if}, 32'd1);
    check_eq("beq_fid", {31'd0, flush_id}, 32'd0);
    idle_inputs(); tick();
    check_eq("beq_single", {31'd0, redirect_valid}, 32'd0);

    // Operand wait: ready low two cycles, then high
    drive_branch(32'h120, 32'h300, 1'b1, 1'b0); tick();
    check_eq("wait_stall1", {31'd0, stall_id}, 32'd1);
    tick();
    check_eq("wait_stall2", {31'd0, stall_id}, 32'd1);
    operand_ready = 1'b1; tick();
    check_eq("wait_stall_end", {31'd0, stall_id}, 32'd0);
    check_eq("wait_pc", redirect_pc, 32'h300);
    idle_inputs(); tick();

    // teq trap, collisions in handler, return
    drive_teq(32'h340); tick();
    check_eq("trap_fif", {31'd0, flush_if}, 32'd1);
    check_eq("trap_fid", {31'd0, flush_id}, 32'd1);
    idle_inputs(); tick();
    check_eq("trap_vec", redirect_pc, 32'h4);
    check_eq("trap_vec_rv", {31'd0, redirect_valid}, 32'd1);
    tick();
    check_eq("trap_epc", epc, 32'h340);
    check_eq("trap_cause", {27'd0, cause}, 32'd13);
    check_eq("trap_active", {31'd0, trap_active}, 32'd1);
    drive_teq(32'h500); tick();
    check_eq("nest_fid", {31'd0, flush_id}, 32'd0);
    check_eq("nest_epc", epc, 32'h340);
    drive_branch(32'h600, 32'h999, 1'b1, 1'b1); eret_valid = 1'b1; tick();
    check_eq("eret_pc", redirect_pc, 32'h344);
    check_eq("eret_fif", {31'd0, flush_if}, 32'd1);
    idle_inputs(); tick();
    check_eq("eret_idle", {31'd0, trap_active}, 32'd0);

    // Reset in TRAP_VECTOR
    drive_teq(32'h700); tick();
    idle_inputs(); tick();
    rst = 1'b1; tick();
    check_eq("rst_rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("rst_epc", epc, 32'd0);
    check_eq("rst_ta", {31'd0, trap_active}, 32'd0);
    idle_inputs();

    // Stats: three branches (two taken) and one teq
    drive_branch(32'h10, 32'h40, 1'b1, 1'b1); tick();
    drive_branch(32'h14, 32'h80, 1'b0, 1'b1); tick();
    drive_branch(32'h18, 32'hC0, 1'b1, 1'b1); tick();
    drive_teq(32'h1C); tick();
    idle_inputs(); tick(); tick();
`ifdef BRANCH_TRAP_STATS_EN
    check_eq("stats_br", stat_branches, 32'd3);
    check_eq("stats_tk", stat_taken, 32'd2);
    check_eq("stats_tr", stat_traps, 32'd1);
`else
    check_eq("stats_br", stat_branches, 32'd0);
    check_eq("stats_tr", stat_traps, 32'd0);
`endif
    eret_valid = 1'b1; tick();
    idle_inputs(); tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle_inputs();
      rst = ($urandom_range(0, 199) == 0);
      id_valid = ($urandom_range(0, 9) < 8);
      op = int'($urandom_range(0, 2));
      id_is_branch_op = (op == 1);
      id_is_teq_op = (op == 2);
      id_pc = {$urandom, 2'b00} ^ 32'hFFFF_FF00;
      id_branch_target = $urandom;
      is_branch = $urandom_range(0, 1) == 1;
      is_teq = $urandom_range(0, 3) == 0;
      operand_ready = ($urandom_range(0, 9) < 7);
      ex_stall = ($urandom_range(0, 99) < 15);
      eret_valid = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
